alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// Command sequencer: buffers ALU commands in a FIFO, presents the head to an external
// combinational ALU and registers its result. Optional sticky overflow: ALU_CMD_SEQ_STICKY_EN.
module alu_cmd_seq #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [3:0]                 in_op,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [3:0]                 alu_op,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carry,
    input  logic                       alu_overflow,
    input  logic                       alu_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [2:0]                 out_flags,
`ifdef ALU_CMD_SEQ_STICKY_EN
    input  logic                       sticky_clr,
    output logic                       sticky_ovf,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * WIDTH + 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [2:0]       out_flags_q, out_flags_d;
    state_e           state_q, state_d;
    logic             push_s, issue_s, nonempty_s;
    logic [EW-1:0]    head_s;

    // FIFO control, head presentation and output register next-state
    always_comb begin
        nonempty_s   = (count_q != CW'(0));
        push_s       = in_valid && in_ready_q;
        issue_s      = nonempty_s && (!out_valid_q || out_ready);
        head_s       = mem_q[rd_ptr_q];
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;

        if (nonempty_s) begin
            {alu_a, alu_b, alu_op} = head_s;
        end else begin
            {alu_a, alu_b, alu_op} = {EW{1'b0}};
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (issue_s) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_flags_d  = {alu_overflow, alu_carry, alu_zero};
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end

        case ({push_s, issue_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // in_ready is registered but always equals "next count not full"
        in_ready_d = (count_d != CW'(DEPTH));
    end

    // Activity state: STALL means a result is held while commands wait behind it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_STALL: begin
                if ((count_d == CW'(0)) && !out_valid_d) begin
                    state_d = ST_IDLE;
                end else if (out_valid_q && !out_ready && (count_d != CW'(0))) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= 3'b000;
            state_q      <= ST_IDLE;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            state_q      <= state_d;
        end
    end

    // Command storage, written at the tail on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_op};
        end
    end

`ifdef ALU_CMD_SEQ_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky overflow: an overflowing issue wins over a same-edge clear
    always_comb begin
        sticky_d = sticky_q;
        if (issue_s && alu_overflow) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Sticky overflow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Randomized and directed bench for alu_cmd_seq against a queue-based reference model.
module tb_alu_cmd_seq;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [3:0]    in_op = 4'd0;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [3:0]    alu_op;
    logic          alu_carry, alu_overflow, alu_zero;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic [2:0]    out_flags;
    logic [CW-1:0] count;
`ifdef ALU_CMD_SEQ_STICKY_EN
    logic          sticky_clr = 1'b0;
    logic          sticky_ovf;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
    } cmd_t;

    cmd_t         mq[$];
    logic         m_ov    = 1'b0;
    logic [W-1:0] m_res   = '0;
    logic [2:0]   m_flags = 3'b000;

    alu_cmd_seq #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
`ifdef ALU_CMD_SEQ_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    // Downstream ALU: returns {overflow, carry, zero, result}
    function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, ov;
        r = '0; c = 1'b0; ov = 1'b0; s = '0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1: begin r = a - b; c = (a < b);
                        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a << 1; c = a[W-1]; end
            4'd6: begin r = a >> 1; c = a[0]; end
            default: r = '0;
        endcase
        return {ov, c, (r == '0), r};
    endfunction

    always_comb {alu_overflow, alu_carry, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour at one rising edge
    task automatic model_update();
        logic [W+2:0] r;
        cmd_t c;
        bit push, iss;
        push = in_valid && (mq.size() < D);
        iss  = (mq.size() > 0) && (!m_ov || out_ready);
        if (iss) begin
            c = mq.pop_front();
            r = alu_fn(c.a, c.b, c.op);
            m_res = r[W-1:0]; m_flags = r[W+2:W]; m_ov = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if (push) mq.push_back('{in_a, in_b, in_op});
    endtask

    task automatic check_all();
        logic [35:0] hexp;
        hexp = '0;
        if (mq.size() > 0) hexp = {mq[0].a, mq[0].b, mq[0].op};
        chk("out_valid", out_valid, m_ov);
        chk("out_result", out_result, m_res);
        chk("out_flags", out_flags, m_flags);
        chk("count", count, mq.size());
        chk("in_ready", in_ready, mq.size() < D);
        chk("alu_ports", {alu_a, alu_b, alu_op}, hexp);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op, input logic rdy);
        in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = rdy;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv, first, last;
        #12;
        chk("reset_count", count, 0);
        chk("reset_out_valid", out_valid, 0);
        #5 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        check_all();

        // Overflowing ADD: result after the second edge
        drive(1'b1, 16'h7FFF, 16'h0001, 4'd0, 1'b1); step();
        drive(1'b0, 16'h0, 16'h0, 4'd0, 1'b1); step();
        chk("add_ovf_valid", out_valid, 1);
        chk("add_ovf_result", out_result, 16'h8000);
        chk("add_ovf_flags", out_flags, 3'b100);
        step();

        // Fill while stalled: first command lands in the output register
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, W'(i), W'(i - 1), 4'd0, 1'b0); step();
        end
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("stall_result", out_result, 16'd1);
        drive(1'b1, 16'hAAAA, 16'h5555, 4'd0, 1'b0); step();
        chk("full_ignored_count", count, 4);
        drive(1'b0, 16'h0, 16'h0, 4'd0, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("drain_valid", out_valid, 1);
            chk("drain_result", out_result, W'(2 * k - 1));
        end
        step();
        chk("drain_done", out_valid, 0);

        // Back-to-back SUB stream
        nv = 0; first = -1; last = -1;
        for (int n = 0; n < 14; n++) begin
            drive(n < 10, 16'd5, 16'd5, 4'd1, 1'b1); step();
            if (out_valid) begin
                nv++; last = n;
                if (first < 0) first = n;
                chk("sub_result", out_result, 16'd0);
                chk("sub_flags", out_flags, 3'b001);
            end
        end
        chk("sub_count", nv, 10);
        chk("sub_no_bubble", last - first + 1, 10);

        // Undefined opcode
        drive(1'b1, 16'h1234, 16'h5678, 4'hF, 1'b1); step();
        drive(1'b0, 16'h0, 16'h0, 4'd0, 1'b1); step();
        chk("undef_result", out_result, 16'd0);
        chk("undef_flags", out_flags, 3'b001);
        step();

        // Reset while stalled with queued commands
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0100 + W'(i), 16'h0001, 4'd0, 1'b0); step();
        end
        drive(1'b0, 16'h0, 16'h0, 4'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_result", out_result, 0);
        mq.delete(); m_ov = 1'b0; m_res = '0; m_flags = 3'b000;
        #4 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("rst_no_stale", out_valid, 0);

`ifdef ALU_CMD_SEQ_STICKY_EN
        drive(1'b1, 16'h7FFF, 16'h0001, 4'd0, 1'b1); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0001, 16'h0001, 4'd0, 1'b1); step();
        end
        drive(1'b0, 16'h0, 16'h0, 4'd0, 1'b1); step(); step();
        chk("sticky_held", sticky_ovf, 1);
        sticky_clr = 1'b1; step();
        sticky_clr = 1'b0;
        chk("sticky_cleared", sticky_ovf, 0);
`endif

        // Randomized traffic with varying backpressure
        for (int n = 0; n < 800; n++) begin
            int vb, rb;
            vb = (n / 100) % 2 ? 80 : 40;
            rb = (n / 150) % 2 ? 30 : 85;
            drive($urandom_range(0, 99) < vb, pick_operand(), pick_operand(),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)),
                  $urandom_range(0, 99) < rb);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
